// File: rtl/onehot_to_bin_util.sv
// onehot_to_bin_util: one-hot core select to binary core index, combinational plus registered copy
// Ports: clk rising-edge clock; reset sync active-low; onehot_in N-bit select;
//   bin_out/zero_out/multi_out combinational index and status;
//   bin_q/valid_q/err_q same results registered one cycle later.
module onehot_to_bin_util #(
  parameter int N = 32,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] onehot_in,
  output logic [W-1:0] bin_out,
  output logic         zero_out,
  output logic         multi_out,
  output logic [W-1:0] bin_q,
  output logic         valid_q,
  output logic         err_q
);
  logic [W-1:0] w_bin;
  logic         w_zero;
  logic         w_multi;
  // Scan from the top down so the lowest set bit is the last write and wins.
  always_comb begin
    w_bin = '0;
    for (int i = N - 1; i >= 0; i--) w_bin = onehot_in[i] ? W'(i) : w_bin;
  end
  assign w_zero    = ~|onehot_in;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_multi   = |(onehot_in & (onehot_in - N'(1)));
  assign bin_out   = w_bin;
  assign zero_out  = w_zero;
  assign multi_out = w_multi;
  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bin_q   <= w_bin;
      valid_q <= !w_zero && !w_multi;
      err_q   <= w_zero || w_multi;
    end
  end
endmodule

// File: tb/tb_onehot_to_bin_util.sv
// tb_onehot_to_bin_util: directed self-checking bench for onehot_to_bin_util at N=32, N=5 and N=1
module tb_onehot_to_bin_util;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] oh = 32'h0000_0001;
  logic [4:0]  bin_out, bin_q;
  logic        zero_out, multi_out, valid_q, err_q;
  logic [4:0]  oh5 = 5'b0;
  logic [2:0]  bin5, bin5_q;
  logic        zero5, multi5, valid5_q, err5_q;
  logic [0:0]  oh1 = 1'b0;
  logic [0:0]  bin1, bin1_q;
  logic        zero1, multi1, valid1_q, err1_q;
  int          vectors = 0;
  int          errs = 0;
  int          prev;

  always #5 clk = ~clk;

  onehot_to_bin_util #(.N(32)) dut (
    .clk(clk), .reset(reset), .onehot_in(oh), .bin_out(bin_out), .zero_out(zero_out),
    .multi_out(multi_out), .bin_q(bin_q), .valid_q(valid_q), .err_q(err_q));
  onehot_to_bin_util #(.N(5)) dut5 (
    .clk(clk), .reset(reset), .onehot_in(oh5), .bin_out(bin5), .zero_out(zero5),
    .multi_out(multi5), .bin_q(bin5_q), .valid_q(valid5_q), .err_q(err5_q));
  onehot_to_bin_util #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .onehot_in(oh1), .bin_out(bin1), .zero_out(zero1),
    .multi_out(multi1), .bin_q(bin1_q), .valid_q(valid1_q), .err_q(err1_q));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic comb(input string tag, input int b, input logic z, input logic m);
    chk({tag, "_bin"}, 32'(bin_out), 32'(b));
    chk({tag, "_zero"}, 32'(zero_out), 32'(z));
    chk({tag, "_multi"}, 32'(multi_out), 32'(m));
    chk({tag, "_excl"}, 32'(zero_out & multi_out), 32'd0);
  endtask

  task automatic regd(input string tag, input int b, input logic v, input logic e);
    chk({tag, "_bin_q"}, 32'(bin_q), 32'(b));
    chk({tag, "_valid_q"}, 32'(valid_q), 32'(v));
    chk({tag, "_err_q"}, 32'(err_q), 32'(e));
  endtask

  initial begin
    @(posedge clk); #1;
    regd("reset", 0, 1'b0, 1'b0);
    comb("t1", 0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    regd("t1", 0, 1'b1, 1'b0);
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); oh = 32'd1 << i; #1;
      comb($sformatf("walk%0d", i), i, 1'b0, 1'b0);
      chk($sformatf("walk%0d_lag", i), 32'(bin_q), 32'(prev));
      @(posedge clk); #1;
      regd($sformatf("walk%0d", i), i, 1'b1, 1'b0);
      prev = i;
    end
    @(negedge clk); oh = 32'h0000_0A00; #1;
    comb("t3", 9, 1'b0, 1'b1);
    @(posedge clk); #1;
    regd("t3", 9, 1'b0, 1'b1);
    @(negedge clk); oh = 32'hFFFF_FFFF; #1;
    comb("allones", 0, 1'b0, 1'b1);
    @(negedge clk); oh = 32'h0000_0000; #1;
    comb("t4", 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    regd("t4", 0, 1'b0, 1'b1);
    @(negedge clk); oh = 32'h8000_0000; reset = 1'b0; #1;
    comb("t5_pre", 31, 1'b0, 1'b0);
    @(posedge clk); #1;
    regd("t5_rst", 0, 1'b0, 1'b0);
    comb("t5_rst", 31, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    regd("t5_rel", 31, 1'b1, 1'b0);
    @(negedge clk); oh5 = 5'b10000; oh1 = 1'b1; #1;
    chk("n5_bin", 32'(bin5), 32'd4);
    chk("n5_zero", 32'(zero5), 32'd0);
    chk("n1_bin", 32'(bin1), 32'd0);
    chk("n1_zero", 32'(zero1), 32'd0);
    chk("n1_multi", 32'(multi1), 32'd0);
    @(posedge clk); #1;
    chk("n5_bin_q", 32'(bin5_q), 32'd4);
    chk("n5_valid_q", 32'(valid5_q), 32'd1);
    chk("n1_valid_q", 32'(valid1_q), 32'd1);
    @(negedge clk); oh5 = 5'b00110; oh1 = 1'b0; #1;
    chk("n5m_bin", 32'(bin5), 32'd1);
    chk("n5m_multi", 32'(multi5), 32'd1);
    chk("n1z_bin", 32'(bin1), 32'd0);
    chk("n1z_zero", 32'(zero1), 32'd1);
    @(posedge clk); #1;
    chk("n5m_err_q", 32'(err5_q), 32'd1);
    chk("n1z_err_q", 32'(err1_q), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
